// File: rtl/dpa_word_align_pkg.sv
// ============================================================================
// dpa_word_align_pkg : shared one-hot state encoding and aligner defaults
// Rev 1.0
// ============================================================================
`default_nettype none

package dpa_word_align_pkg;

    localparam int         DPA_DATA_WIDTH    = 8;
    localparam logic [7:0] DPA_TRAIN_PATTERN = 8'hA1;
    localparam int         DPA_STATE_WIDTH   = 6;

    // One-hot so the debug port can be decoded bit-by-bit alongside DPA_FSM
    typedef enum logic [DPA_STATE_WIDTH-1:0] {
        ST_IDLE    = 6'b000001,
        ST_CHECK   = 6'b000010,
        ST_SLIP    = 6'b000100,
        ST_SETTLE  = 6'b001000,
        ST_ALIGNED = 6'b010000,
        ST_ERROR   = 6'b100000
    } align_state_e;

endpackage

`default_nettype wire

// File: rtl/dpa_word_align_if.sv
// ============================================================================
// dpa_word_align_if : ISERDES-side and downstream signals of the word aligner
// Rev 1.0
// ============================================================================
`default_nettype none

interface dpa_word_align_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  locked;
    logic                  start;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  bitslip;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_out_valid;
    logic                  aligned;
    logic                  align_err;
    logic [3:0]            slip_cnt;
    logic [5:0]            state;

    modport master (
        output locked, start, data_in,
        input  bitslip, data_out, data_out_valid, aligned, align_err, slip_cnt, state
    );

    modport slave (
        input  locked, start, data_in,
        output bitslip, data_out, data_out_valid, aligned, align_err, slip_cnt, state
    );
endinterface

`default_nettype wire

// File: rtl/dpa_word_align_settle_timer.sv
// ============================================================================
// dpa_word_align_settle_timer : load/expire down-counter for post-slip settling
// Rev 1.0
// ============================================================================
`default_nettype none

module dpa_word_align_settle_timer #(
    parameter int CYCLES = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic load,
    input  wire logic clear,
    output logic      expired
);
    localparam int          CW       = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Loading CYCLES-1 makes expiry land on the last of CYCLES settle cycles
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = LOAD_VAL;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/dpa_word_align.sv
// ============================================================================
// dpa_word_align : bitslips the ISERDES until the training word is stable
// Rev 1.0
// ============================================================================
`default_nettype none

module dpa_word_align
    import dpa_word_align_pkg::*;
#(
    parameter int                    DATA_WIDTH    = DPA_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DATA_WIDTH'(DPA_TRAIN_PATTERN),
    parameter int                    MATCH_COUNT   = 16,
    parameter int                    SETTLE_CYCLES = 4,
    parameter int                    MAX_SLIPS     = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    dpa_word_align_if.slave bus
);
    localparam int            MW         = $clog2(MATCH_COUNT + 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(MATCH_COUNT - 1);
    localparam logic [3:0]    SLIP_LIMIT = 4'(MAX_SLIPS);

    align_state_e          state_q,    state_d;
    logic [MW-1:0]         match_cnt_q, match_cnt_d;
    logic [3:0]            slip_cnt_q, slip_cnt_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  tmr_load;
    logic                  tmr_clear;
    logic                  tmr_expired;

    dpa_word_align_settle_timer #(
        .CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .clear   (tmr_clear),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        slip_cnt_d  = slip_cnt_q;
        data_out_d  = bus.data_in;
        tmr_load    = 1'b0;
        tmr_clear   = 1'b0;

        // Lost lock or a realign request both restart from IDLE with clean counters
        if (!bus.locked || bus.start) begin
            state_d     = ST_IDLE;
            match_cnt_d = '0;
            slip_cnt_d  = '0;
            tmr_clear   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d     = ST_CHECK;
                    match_cnt_d = '0;
                    slip_cnt_d  = '0;
                    tmr_clear   = 1'b1;
                end
                ST_CHECK: begin
                    if (bus.data_in == TRAIN_PATTERN) begin
                        match_cnt_d = match_cnt_q + 1'b1;
                        if (match_cnt_q == MATCH_LAST) begin
                            state_d = ST_ALIGNED;
                        end
                    end else if (slip_cnt_q < SLIP_LIMIT) begin
                        state_d     = ST_SLIP;
                        match_cnt_d = '0;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
                ST_SLIP: begin
                    if (slip_cnt_q != 4'hF) begin
                        slip_cnt_d = slip_cnt_q + 1'b1;
                    end
                    state_d  = ST_SETTLE;
                    tmr_load = 1'b1;
                end
                ST_SETTLE: begin
                    if (tmr_expired) begin
                        state_d     = ST_CHECK;
                        match_cnt_d = '0;
                    end
                end
                ST_ALIGNED: state_d = ST_ALIGNED;
                ST_ERROR:   state_d = ST_ERROR;
                default: begin
                    state_d     = ST_IDLE;
                    match_cnt_d = '0;
                    slip_cnt_d  = '0;
                    tmr_clear   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            match_cnt_q <= '0;
            slip_cnt_q  <= '0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            slip_cnt_q  <= slip_cnt_d;
            data_out_q  <= data_out_d;
        end
    end

    // All status outputs decode straight from the state register
    assign bus.bitslip        = (state_q == ST_SLIP);
    assign bus.aligned        = (state_q == ST_ALIGNED);
    assign bus.data_out_valid = (state_q == ST_ALIGNED);
    assign bus.align_err      = (state_q == ST_ERROR);
    assign bus.slip_cnt       = slip_cnt_q;
    assign bus.state          = state_q;
    assign bus.data_out       = data_out_q;

endmodule

`default_nettype wire

// File: tb/tb_dpa_word_align.sv
// ============================================================================
// tb_dpa_word_align : directed/randomized bench with a rotate-on-bitslip ISERDES model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dpa_word_align;
    localparam logic [7:0] PAT = 8'hA1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dpa_word_align_if #(.DATA_WIDTH(8)) bus ();

    dpa_word_align #(
        .DATA_WIDTH    (8),
        .TRAIN_PATTERN (8'hA1),
        .MATCH_COUNT   (16),
        .SETTLE_CYCLES (4),
        .MAX_SLIPS     (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // ISERDES model state: current rotation and pending bitslip delay
    int         off        = 0;
    int         pend       = 0;
    int         cyc        = 0;
    int         pulses     = 0;
    int         last_pulse = -1;
    int         min_gap    = 1000;
    bit         garbage    = 1'b0;
    bit         force_en   = 1'b0;
    bit         user       = 1'b0;
    logic [7:0] force_val  = 8'h00;

    function automatic logic [7:0] rotl(input logic [7:0] p, input int n);
        logic [15:0] t;
        t = {p, p} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] model_data();
        if (user)     return 8'($urandom);
        if (garbage)  return 8'h00;
        if (force_en) return force_val;
        return rotl(PAT, off);
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) off = (off + 7) % 8;
        end
        bus.data_in = model_data();
    end

    always @(negedge clk) begin
        if (bus.bitslip) begin
            pulses = pulses + 1;
            if (last_pulse >= 0 && (cyc - last_pulse) < min_gap) min_gap = cyc - last_pulse;
            last_pulse = cyc;
            pend = 2;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_now();
        bus.data_in = model_data();
    endtask

    task automatic clr_track();
        pulses     = 0;
        last_pulse = -1;
        min_gap    = 1000;
    endtask

    // Returns the tick index (first..limit) at which aligned/align_err first rises, else -1
    task automatic wait_first(input bit err, input int first, input int limit, output int k);
        k = -1;
        for (int i = first; i <= limit; i++) begin
            tick();
            if (err ? bus.align_err : bus.aligned) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic idle_setup();
        bus.locked = 1'b0;
        bus.start  = 1'b0;
        user       = 1'b0;
        garbage    = 1'b0;
        force_en   = 1'b0;
        tick();
        tick();
        pend = 0;
    endtask

    // Expected: each needed slip costs mismatch+SLIP+4 SETTLE = 6 edges, then 16 matches
    task automatic align_run(input int o);
        int k;
        idle_setup();
        off = o;
        drive_now();
        clr_track();
        bus.locked = 1'b1;
        tick();
        chk("check_entry", 32'(bus.state), 32'h02);
        wait_first(1'b0, 2, 300, k);
        chk("align_time", 32'(k), 32'(17 + 6 * o));
        chk("pulse_count", 32'(pulses), 32'(o));
        if (o > 1) chk("pulse_gap_ge6", 32'(min_gap >= 6), 32'd1);
        chk("slip_cnt_aligned", 32'(bus.slip_cnt), 32'(o));
        chk("data_out_pat", 32'(bus.data_out), 32'(PAT));
        chk("data_out_valid", 32'(bus.data_out_valid), 32'd1);
        chk("no_err_aligned", 32'(bus.align_err), 32'd0);
    endtask

    initial begin
        int         k;
        int         o;
        logic [7:0] saved;

        bus.locked  = 1'b0;
        bus.start   = 1'b0;
        bus.data_in = 8'h00;
        #12;
        chk("rst_state", 32'(bus.state), 32'h01);
        chk("rst_bitslip", 32'(bus.bitslip), 32'd0);
        chk("rst_aligned", 32'(bus.aligned), 32'd0);
        chk("rst_slip_cnt", 32'(bus.slip_cnt), 32'd0);
        chk("rst_data_out", 32'(bus.data_out), 32'd0);
        tick();
        rst_n = 1'b1;

        // Already aligned stream, then a fixed 3-position rotation, then a random one
        align_run(0);
        align_run(3);
        o = int'($urandom_range(1, 7));
        align_run(o);

        // Aligned: arbitrary user data is forwarded with one cycle of latency
        user = 1'b1;
        clr_track();
        for (int i = 0; i < 8; i++) begin
            saved = bus.data_in;
            tick();
            chk("user_data_out", 32'(bus.data_out), 32'(saved));
            chk("user_aligned", 32'(bus.aligned), 32'd1);
        end
        chk("user_no_slip", 32'(pulses), 32'd0);

        // Asynchronous reset between edges while aligned
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_aligned", 32'(bus.aligned), 32'd0);
        chk("arst_valid", 32'(bus.data_out_valid), 32'd0);
        chk("arst_bitslip", 32'(bus.bitslip), 32'd0);
        chk("arst_slip_cnt", 32'(bus.slip_cnt), 32'd0);
        chk("arst_state", 32'(bus.state), 32'h01);
        tick();
        user = 1'b0;
        pend = 0;
        drive_now();
        rst_n = 1'b1;
        tick();
        chk("rearm_check", 32'(bus.state), 32'h02);
        wait_first(1'b0, 2, 300, k);
        chk("realign_time", 32'(k), 32'd17);

        // Start and locked-low together while aligned
        clr_track();
        bus.start  = 1'b1;
        bus.locked = 1'b0;
        tick();
        chk("abort_state", 32'(bus.state), 32'h01);
        chk("abort_err", 32'(bus.align_err), 32'd0);
        bus.start = 1'b0;
        repeat (3) tick();
        chk("abort_no_slip", 32'(pulses), 32'd0);

        // Stream that never matches: 8 slips then ERROR
        idle_setup();
        garbage = 1'b1;
        drive_now();
        clr_track();
        bus.locked = 1'b1;
        tick();
        wait_first(1'b1, 2, 300, k);
        chk("err_time", 32'(k), 32'd50);
        chk("err_pulses", 32'(pulses), 32'd8);
        chk("err_slip_cnt", 32'(bus.slip_cnt), 32'd8);
        chk("err_not_aligned", 32'(bus.aligned), 32'd0);
        repeat (20) tick();
        chk("err_no_9th", 32'(pulses), 32'd8);
        chk("err_hold", 32'(bus.state), 32'h20);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("err_start_idle", 32'(bus.state), 32'h01);
        chk("err_start_slip", 32'(bus.slip_cnt), 32'd0);
        chk("err_start_clear", 32'(bus.align_err), 32'd0);

        // 10 matches, one mismatch, then a full fresh 16-match run is needed
        idle_setup();
        force_en  = 1'b1;
        force_val = PAT;
        drive_now();
        clr_track();
        bus.locked = 1'b1;
        tick();
        repeat (10) tick();
        chk("m10_still_check", 32'(bus.state), 32'h02);
        force_val = 8'h55;
        drive_now();
        tick();
        chk("m10_slip", 32'(bus.state), 32'h04);
        chk("m10_bitslip", 32'(bus.bitslip), 32'd1);
        force_val = PAT;
        drive_now();
        wait_first(1'b0, 13, 300, k);
        chk("m10_restart_time", 32'(k), 32'd33);
        chk("m10_slip_cnt", 32'(bus.slip_cnt), 32'd1);

        // Lock lost while settling
        idle_setup();
        force_en  = 1'b1;
        force_val = 8'h55;
        drive_now();
        bus.locked = 1'b1;
        tick();
        tick();
        tick();
        chk("settle_entry", 32'(bus.state), 32'h08);
        bus.locked = 1'b0;
        tick();
        chk("unlock_state", 32'(bus.state), 32'h01);
        chk("unlock_bitslip", 32'(bus.bitslip), 32'd0);
        chk("unlock_slip_cnt", 32'(bus.slip_cnt), 32'd0);
        chk("unlock_aligned", 32'(bus.aligned), 32'd0);
        chk("unlock_err", 32'(bus.align_err), 32'd0);
        chk("unlock_valid", 32'(bus.data_out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
